phase_unwrap_sequencer: RTL

Control sequencer for the phase unwrapper in the RedPitaya PLL/lock-in chain. It watches the amplitude and wrapped phase coming from the LMS phase/amplitude detector, and drives the unwrapper's `enable` only while the signal is qualified. It also counts signed 2π turns and supervises the unwrapped phase range. On over-range it either re-centers the unwrapper automatically or latches a fault for the host.

---
 rtl/phase_unwrap_sequencer_pkg.sv | 15 +
 rtl/phase_unwrap_sequencer_if.sv | 12 +
 rtl/phase_unwrap_sequencer_turn.sv | 39 +++
 rtl/phase_unwrap_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/phase_unwrap_sequencer_pkg.sv
// Shared definitions for the phase unwrapper sequencer: state encoding and Q21 phase constants.
package phase_unwrap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUALIFY  = 3'd1,
    ST_TRACK    = 3'd2,
    ST_RECENTER = 3'd3,
    ST_FAULT    = 3'd4
  } pu_state_t;

  localparam int PI_Q21     = 6588397;
  localparam int TWO_PI_Q21 = 13176795;

endpackage

// File: rtl/phase_unwrap_sequencer_if.sv
// Amplitude/phase sample stream from the LMS detector, one valid shared by both fields.
interface phase_unwrap_sequencer_if #(
  parameter int AM_WIDTH = 24,
  parameter int PH_WIDTH = 24
);
  logic signed [AM_WIDTH-1:0] am_tdata;
  logic signed [PH_WIDTH-1:0] ph_tdata;
  logic                       tvalid;

  modport master (output am_tdata, output ph_tdata, output tvalid);
  modport slave  (input  am_tdata, input  ph_tdata, input  tvalid);
endinterface

// File: rtl/phase_unwrap_sequencer_turn.sv
// Wrap detector on consecutive wrapped-phase samples plus a saturating signed turn counter.
module phase_turn_counter
  import phase_unwrap_pkg::*;
#(
  parameter int PH_WIDTH   = 24,
  parameter int TURN_WIDTH = 16
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [PH_WIDTH-1:0]   ph,
  input  logic signed [PH_WIDTH-1:0]   ph_prev,
  output logic signed [TURN_WIDTH-1:0] turn_count
);

  localparam logic signed [PH_WIDTH:0]     PI_W  = (PH_WIDTH+1)'(PI_Q21);
  localparam logic signed [TURN_WIDTH-1:0] T_MAX = {1'b0, {(TURN_WIDTH-1){1'b1}}};
  localparam logic signed [TURN_WIDTH-1:0] T_MIN = {1'b1, {(TURN_WIDTH-1){1'b0}}};

  // One extra bit so the difference of two full-range samples cannot overflow.
  logic signed [PH_WIDTH:0] d;
  assign d = {ph[PH_WIDTH-1], ph} - {ph_prev[PH_WIDTH-1], ph_prev};

  always_ff @(posedge aclk) begin
    if (reset) begin
      turn_count <= '0;
    end else if (clr) begin
      turn_count <= '0;
    end else if (en) begin
      if (d > PI_W) begin
        if (turn_count != T_MIN) turn_count <= turn_count - TURN_WIDTH'(1);
      end else if (d < -PI_W) begin
        if (turn_count != T_MAX) turn_count <= turn_count + TURN_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/phase_unwrap_sequencer.sv
// Qualifies the detector signal, gates the unwrapper enable and supervises unwrapped phase range.
//   state    | meaning
//   IDLE     | disarmed, unwrapper off, counters cleared
//   QUALIFY  | counting consecutive above-threshold samples
//   TRACK    | unwrapper on, turns counted, range and lock supervised
//   RECENTER | unwrapper held off for RECENTER_CYCLES clocks to clear it
//   FAULT    | over-range latched, waits for arm to drop
module phase_unwrap_sequencer
  import phase_unwrap_pkg::*;
#(
  parameter int AM_WIDTH        = 24,
  parameter int PH_WIDTH        = 24,
  parameter int UW_WIDTH        = 32,
  parameter int QCNT_WIDTH      = 16,
  parameter int TURN_WIDTH      = 16,
  parameter int RECENTER_CYCLES = 4
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         arm,
  input  logic                         auto_recenter,
  input  logic signed [AM_WIDTH-1:0]   amp_threshold,
  input  logic [QCNT_WIDTH-1:0]        qualify_count,
  input  logic [UW_WIDTH-2:0]          phase_limit,
  phase_unwrap_sequencer_if.slave      s_axis,
  input  logic signed [UW_WIDTH-1:0]   unwrapped_tdata,
  output logic                         unwrap_enable,
  output logic signed [TURN_WIDTH-1:0] turn_count,
  output logic [7:0]                   recenter_count,
  output logic [2:0]                   state,
  output logic                         locked,
  output logic                         fault
);

  localparam int BW = $clog2(RECENTER_CYCLES + 1);

  pu_state_t                 st;
  logic [QCNT_WIDTH-1:0]     qcnt;
  logic [BW-1:0]             blank;
  logic [BW-1:0]             rc_cnt;
  logic signed [PH_WIDTH-1:0] ph_prev;

  logic [QCNT_WIDTH-1:0] qual_target;
  logic [QCNT_WIDTH-1:0] qcnt_inc;
  logic                  amp_ok, sample_hi, sample_lo;
  logic [UW_WIDTH-1:0]   uw_abs;
  logic [UW_WIDTH-2:0]   uw_mag;
  logic                  over_rng, lose_lock, turn_clr, turn_en;

  assign qual_target = (qualify_count == '0) ? QCNT_WIDTH'(1) : qualify_count;
  assign qcnt_inc    = qcnt + QCNT_WIDTH'(1);
  assign amp_ok      = s_axis.am_tdata >= amp_threshold;
  assign sample_hi   = s_axis.tvalid && amp_ok;
  assign sample_lo   = s_axis.tvalid && !amp_ok;

  // Negating the most negative value leaves the MSB set; clamp that case to full scale.
  assign uw_abs = unwrapped_tdata[UW_WIDTH-1] ? -unwrapped_tdata : unwrapped_tdata;
  assign uw_mag = uw_abs[UW_WIDTH-1] ? {(UW_WIDTH-1){1'b1}} : uw_abs[UW_WIDTH-2:0];

  assign over_rng  = (st == ST_TRACK) && (blank == '0) && (uw_mag > phase_limit);
  assign lose_lock = (st == ST_TRACK) && sample_lo && (qcnt_inc >= qual_target);

  // Clear lands on the same edge as the state change that demands it; FAULT freezes the count.
  assign turn_clr = !arm || (st == ST_IDLE) || (st == ST_QUALIFY) || (st == ST_RECENTER) ||
                    (over_rng && auto_recenter) || (!over_rng && lose_lock);
  assign turn_en  = (st == ST_TRACK) && s_axis.tvalid;

  phase_turn_counter #(
    .PH_WIDTH   (PH_WIDTH),
    .TURN_WIDTH (TURN_WIDTH)
  ) u_turn (
    .aclk       (aclk),
    .reset      (reset),
    .clr        (turn_clr),
    .en         (turn_en),
    .ph         (s_axis.ph_tdata),
    .ph_prev    (ph_prev),
    .turn_count (turn_count)
  );

  always_ff @(posedge aclk) begin
    if (reset) begin
      st             <= ST_IDLE;
      qcnt           <= '0;
      blank          <= '0;
      rc_cnt         <= '0;
      recenter_count <= '0;
      ph_prev        <= '0;
    end else begin
      if (s_axis.tvalid) ph_prev <= s_axis.ph_tdata;

      if (!arm) begin
        st             <= ST_IDLE;
        qcnt           <= '0;
        blank          <= '0;
        rc_cnt         <= '0;
        recenter_count <= '0;
      end else begin
        case (st)
          ST_IDLE: begin
            st             <= ST_QUALIFY;
            qcnt           <= '0;
            recenter_count <= '0;
          end
          ST_QUALIFY: begin
            if (sample_hi) begin
              if (qcnt_inc >= qual_target) begin
                st    <= ST_TRACK;
                qcnt  <= '0;
                blank <= BW'(RECENTER_CYCLES);
              end else begin
                qcnt <= qcnt_inc;
              end
            end else if (sample_lo) begin
              qcnt <= '0;
            end
          end
          ST_TRACK: begin
            if (blank != '0) blank <= blank - BW'(1);
            if (over_rng) begin
              qcnt <= '0;
              if (auto_recenter) begin
                st     <= ST_RECENTER;
                rc_cnt <= BW'(RECENTER_CYCLES - 1);
                if (recenter_count != 8'hFF) recenter_count <= recenter_count + 8'd1;
              end else begin
                st <= ST_FAULT;
              end
            end else if (lose_lock) begin
              st   <= ST_QUALIFY;
              qcnt <= '0;
            end else if (sample_lo) begin
              qcnt <= qcnt_inc;
            end else if (sample_hi) begin
              qcnt <= '0;
            end
          end
          ST_RECENTER: begin
            if (rc_cnt == '0) begin
              st    <= ST_TRACK;
              qcnt  <= '0;
              blank <= BW'(RECENTER_CYCLES);
            end else begin
              rc_cnt <= rc_cnt - BW'(1);
            end
          end
          ST_FAULT: st <= ST_FAULT;
          default:  st <= ST_IDLE;
        endcase
      end
    end
  end

  assign state         = st;
  assign unwrap_enable = (st == ST_TRACK);
  assign locked        = (st == ST_TRACK);
  assign fault         = (st == ST_FAULT);

endmodule
